// File: rtl/online_pkg.sv
// Shared definitions for the radix-2 online multiplier datapath stages.
// Digits are encoded as {plus,minus} flag pairs; the estimate is a small signed integer in units of 2^-2.
package online_pkg;

    localparam int DEF_BITS = 9;
    localparam int EST_W    = 6;

    localparam logic [1:0] DIG_POS  = 2'b10;
    localparam logic [1:0] DIG_ZERO = 2'b00;
    localparam logic [1:0] DIG_NEG  = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        RUN
    } state_t;

endpackage

// File: rtl/online_digit_select.sv
// Combinational digit selection and residual-top recode for the online multiplier.
// Works only on the four most significant borrow-save positions of the adder sum.
module online_digit_select
    import online_pkg::*;
(
    input  logic       run,
    input  logic [3:0] v_plus_top,
    input  logic [3:0] v_minus_top,
    output logic [1:0] digit,
    output logic [2:0] u_plus,
    output logic [2:0] u_minus,
    output logic       ovf
);

    logic signed [EST_W-1:0] est;
    logic signed [EST_W-1:0] u;
    logic signed [EST_W-1:0] sat;
    logic signed [EST_W-1:0] neg;

    // Fields are unsigned magnitudes; the widened difference covers -15..15.
    // The recoded top keeps at most 3 bits of magnitude, so |u| > 7 must saturate.
    always_comb begin
        est = $signed({2'b00, v_plus_top}) - $signed({2'b00, v_minus_top});

        digit = DIG_ZERO;
        if (run) begin
            if (est >= 6'sd2) begin
                digit = DIG_POS;
            end else if (est <= -6'sd3) begin
                digit = DIG_NEG;
            end
        end

        u = est;
        if (digit == DIG_POS) begin
            u = est - 6'sd4;
        end else if (digit == DIG_NEG) begin
            u = est + 6'sd4;
        end

        ovf = (u > 6'sd7) || (u < -6'sd7);

        sat = u;
        if (u > 6'sd7) begin
            sat = 6'sd7;
        end else if (u < -6'sd7) begin
            sat = -6'sd7;
        end

        neg     = -sat;
        u_plus  = 3'b000;
        u_minus = 3'b000;
        if (sat >= 6'sd0) begin
            u_plus = 3'(sat);
        end else begin
            u_minus = 3'(neg);
        end
    end

endmodule

// File: rtl/online_mult_select_stage.sv
// Digit-selection / residual-update stage of the radix-2 online multiplier.
// Sequences the online-delay warm-up, then emits NDIGITS digits while registering W = 2*(V - p).
module online_mult_select_stage
    import online_pkg::*;
#(
    parameter int BITS    = DEF_BITS,
    parameter int NDIGITS = 8,
    parameter int DELTA   = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            in_valid,
    input  logic [BITS-1:0] v_plus,
    input  logic [BITS-1:0] v_minus,
    output logic [BITS-1:0] w_plus,
    output logic [BITS-1:0] w_minus,
    output logic            p_plus,
    output logic            p_minus,
    output logic            out_valid,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int WW = (DELTA   > 0) ? $clog2(DELTA + 1)   : 1;
    localparam int DW = (NDIGITS > 0) ? $clog2(NDIGITS + 1) : 1;
    localparam logic [WW-1:0] WARM_LAST = WW'(DELTA - 1);
    localparam logic [DW-1:0] DIG_LAST  = DW'(NDIGITS - 1);

    state_t          state;
    state_t          state_nxt;
    logic [WW-1:0]   warm_cnt;
    logic [DW-1:0]   dig_cnt;
    logic            take_start;
    logic            take_warm;
    logic            take_run;
    logic            run_last;
    logic            in_run;
    logic [1:0]      digit;
    logic [2:0]      u_plus;
    logic [2:0]      u_minus;
    logic            ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = WARMUP;
            WARMUP:  if (in_valid && warm_cnt == WARM_LAST) state_nxt = RUN;
            RUN:     if (in_valid && dig_cnt == DIG_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A start in IDLE takes priority over a simultaneous in_valid, whose data is dropped.
    always_comb begin
        busy       = (state != IDLE);
        in_run     = (state == RUN);
        take_start = (state == IDLE) && start;
        take_warm  = (state == WARMUP) && in_valid;
        take_run   = in_run && in_valid;
        run_last   = take_run && (dig_cnt == DIG_LAST);
    end

    online_digit_select u_select (
        .run         (in_run),
        .v_plus_top  (v_plus[BITS-1 -: 4]),
        .v_minus_top (v_minus[BITS-1 -: 4]),
        .digit       (digit),
        .u_plus      (u_plus),
        .u_minus     (u_minus),
        .ovf         (ovf)
    );

    // Residual is the recoded top digits followed by the untouched low bits, shifted left by one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_plus    <= '0;
            w_minus   <= '0;
            p_plus    <= 1'b0;
            p_minus   <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            warm_cnt  <= '0;
            dig_cnt   <= '0;
        end else begin
            out_valid <= take_run;
            done      <= run_last;
            if (take_start) begin
                w_plus   <= '0;
                w_minus  <= '0;
                err      <= 1'b0;
                warm_cnt <= '0;
                dig_cnt  <= '0;
            end else if (take_warm || take_run) begin
                w_plus  <= {u_plus,  v_plus[BITS-5:0],  1'b0};
                w_minus <= {u_minus, v_minus[BITS-5:0], 1'b0};
                if (ovf) begin
                    err <= 1'b1;
                end
                if (take_warm) begin
                    warm_cnt <= warm_cnt + WW'(1);
                end
                if (take_run) begin
                    {p_plus, p_minus} <= digit;
                    dig_cnt           <= dig_cnt + DW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_online_mult_select_stage.sv
// Directed and model-checked bench for the online multiplier selection stage.
module tb_online_mult_select_stage;

    localparam int B = 9;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         in_valid;
    logic [B-1:0] v_plus;
    logic [B-1:0] v_minus;
    logic [B-1:0] w_plus;
    logic [B-1:0] w_minus;
    logic         p_plus;
    logic         p_minus;
    logic         out_valid;
    logic         busy;
    logic         done;
    logic         err;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [B-1:0] vp;
        logic [B-1:0] vm;
        logic         ep;
        logic         em;
        logic [B-1:0] ewp;
        logic [B-1:0] ewm;
        logic         eerr;
    } vec_t;

    vec_t run_tab [8];

    always #5 clk = ~clk;

    online_mult_select_stage dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .v_plus    (v_plus),
        .v_minus   (v_minus),
        .w_plus    (w_plus),
        .w_minus   (w_minus),
        .p_plus    (p_plus),
        .p_minus   (p_minus),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one cycle of inputs at a falling edge; outputs are settled at the next falling edge.
    task automatic applyStimulus(input logic s, input logic iv, input logic [B-1:0] vp, input logic [B-1:0] vm);
        start    = s;
        in_valid = iv;
        v_plus   = vp;
        v_minus  = vm;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        int fp, fm, est, pm, expv, gotv;
        logic [B-1:0] vp, vm;

        run_tab[0] = '{9'h040, 9'h000, 1'b1, 1'b0, 9'h000, 9'h080, 1'b0};
        run_tab[1] = '{9'h000, 9'h060, 1'b0, 1'b1, 9'h040, 9'h000, 1'b0};
        run_tab[2] = '{9'h020, 9'h000, 1'b0, 1'b0, 9'h040, 9'h000, 1'b0};
        run_tab[3] = '{9'h03F, 9'h000, 1'b0, 1'b0, 9'h07E, 9'h000, 1'b0};
        run_tab[4] = '{9'h000, 9'h0B5, 1'b0, 1'b1, 9'h000, 9'h06A, 1'b0};
        run_tab[5] = '{9'h0C3, 9'h041, 1'b1, 1'b0, 9'h006, 9'h002, 1'b0};
        run_tab[6] = '{9'h000, 9'h040, 1'b0, 1'b0, 9'h000, 9'h080, 1'b0};
        run_tab[7] = '{9'h1E0, 9'h000, 1'b1, 1'b0, 9'h1C0, 9'h000, 1'b1};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; v_plus = '0; v_minus = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_w_plus", 32'(w_plus), 0);
        checkOutput("rst_w_minus", 32'(w_minus), 0);
        checkOutput("rst_p", 32'({p_plus, p_minus}), 0);
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_err", 32'(err), 0);
        rst = 1'b0;
        @(negedge clk);

        // Operation 1: directed warm-up and table of RUN digits with idle gaps.
        applyStimulus(1'b1, 1'b0, '0, '0);
        checkOutput("start_busy", 32'(busy), 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 9'h020, 9'h000);
            checkOutput("warm_out_valid", 32'(out_valid), 0);
            checkOutput("warm_w_plus", 32'(w_plus), 32'h040);
            checkOutput("warm_w_minus", 32'(w_minus), 0);
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, run_tab[i].vp, run_tab[i].vm);
            checkOutput("run_out_valid", 32'(out_valid), 1);
            checkOutput("run_p_plus", 32'(p_plus), 32'(run_tab[i].ep));
            checkOutput("run_p_minus", 32'(p_minus), 32'(run_tab[i].em));
            checkOutput("run_w_plus", 32'(w_plus), 32'(run_tab[i].ewp));
            checkOutput("run_w_minus", 32'(w_minus), 32'(run_tab[i].ewm));
            checkOutput("run_err", 32'(err), 32'(run_tab[i].eerr));
            checkOutput("run_done", 32'(done), (i == 7) ? 1 : 0);
            checkOutput("run_busy", 32'(busy), (i == 7) ? 0 : 1);
            if (i < 7) begin
                repeat (i % 4) begin
                    @(negedge clk);
                    checkOutput("gap_out_valid", 32'(out_valid), 0);
                end
            end
            if (i == 3) begin
                applyStimulus(1'b1, 1'b0, '0, '0);
                checkOutput("start_in_run_busy", 32'(busy), 1);
                checkOutput("start_in_run_w_held", 32'(w_plus), 32'h07E);
            end
        end
        @(negedge clk);
        checkOutput("after_done_pulse", 32'(done), 0);
        checkOutput("after_busy", 32'(busy), 0);
        checkOutput("err_sticky", 32'(err), 1);

        applyStimulus(1'b0, 1'b1, 9'h040, 9'h000);
        checkOutput("idle_valid_w_held", 32'(w_plus), 32'h1C0);
        checkOutput("idle_valid_out_valid", 32'(out_valid), 0);
        checkOutput("idle_valid_busy", 32'(busy), 0);

        // Operation 2: start and in_valid together, then a random stream against a value model.
        applyStimulus(1'b1, 1'b1, 9'h1E0, 9'h000);
        checkOutput("start_wins_busy", 32'(busy), 1);
        checkOutput("start_clears_err", 32'(err), 0);
        checkOutput("start_clears_w", 32'({w_plus, w_minus}), 0);
        for (int k = 0; k < 11; k++) begin
            fp = int'($urandom_range(7, 0));
            fm = int'($urandom_range(7, 0));
            vp = {4'(fp), 5'($urandom_range(31, 0))};
            vm = {4'(fm), 5'($urandom_range(31, 0))};
            est = fp - fm;
            pm = 0;
            if (k >= 3) begin
                if (est >= 2) pm = 1;
                else if (est <= -3) pm = -1;
            end
            applyStimulus(1'b0, 1'b1, vp, vm);
            expv = 2 * (int'(vp) - int'(vm) - 128 * pm);
            gotv = int'(w_plus) - int'(w_minus);
            checkOutput("rand_w_value", 32'(gotv), 32'(expv));
            checkOutput("rand_out_valid", 32'(out_valid), (k >= 3) ? 1 : 0);
            if (k >= 3) begin
                checkOutput("rand_p_plus", 32'(p_plus), (pm == 1) ? 1 : 0);
                checkOutput("rand_p_minus", 32'(p_minus), (pm == -1) ? 1 : 0);
            end
            checkOutput("rand_done", 32'(done), (k == 10) ? 1 : 0);
        end
        checkOutput("rand_err", 32'(err), 0);
        @(negedge clk);
        checkOutput("rand_end_busy", 32'(busy), 0);

        // Operation 3: asynchronous reset after the fourth RUN digit.
        applyStimulus(1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 9'h020, 9'h000);
        applyStimulus(1'b0, 1'b1, 9'h1E0, 9'h000);
        applyStimulus(1'b0, 1'b1, 9'h040, 9'h000);
        applyStimulus(1'b0, 1'b1, 9'h000, 9'h060);
        applyStimulus(1'b0, 1'b1, 9'h020, 9'h000);
        checkOutput("pre_reset_err", 32'(err), 1);
        checkOutput("pre_reset_busy", 32'(busy), 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rst_busy", 32'(busy), 0);
        checkOutput("mid_rst_w", 32'({w_plus, w_minus}), 0);
        checkOutput("mid_rst_err", 32'(err), 0);
        checkOutput("mid_rst_out_valid", 32'(out_valid), 0);
        checkOutput("mid_rst_p", 32'({p_plus, p_minus}), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("post_rst_no_done", 32'(done), 0);
            checkOutput("post_rst_busy", 32'(busy), 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
